// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous RAM port between the CPU and a debug agent.
// Optional starvation guard is enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        cpu_halted,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_busy,
    output logic        dbg_done,
    output logic        dbg_drop,
    output logic [31:0] dbg_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_PEND   = 2'd1,
        D_RDWAIT = 2'd2
    } d_state_t;

    d_state_t    state_reg, state_next;
    logic        cmd_we_reg;
    logic [31:0] cmd_addr_reg;
    logic [31:0] cmd_wdata_reg;
    logic        done_reg;
    logic        drop_reg;
    logic        rvalid_reg;
    logic [31:0] dbg_rdata_reg;
    logic        dbg_issue;
    logic        starve_force;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_reg, starve_cnt_next;

    assign starve_force = (state_reg == D_PEND) && (starve_cnt_reg >= STARVE_LIMIT_W);

    // Counts only the pending cycles the CPU actually wins.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (dbg_issue)
            starve_cnt_next = 4'd0;
        else if (state_reg == D_PEND && cpu_req && !cpu_halted)
            starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)
            starve_cnt_reg <= 4'd0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end
`else
    logic [3:0] unused_starve_limit;
    assign unused_starve_limit = 4'(STARVE_LIMIT);
    assign starve_force = 1'b0;
`endif

    assign dbg_issue = cpu_rstn && (state_reg == D_PEND)
                       && (!cpu_req || cpu_halted || starve_force);
    assign cpu_gnt   = cpu_rstn && cpu_req && !dbg_issue;
    assign mem_en    = cpu_gnt || dbg_issue;
    assign mem_we    = dbg_issue ? cmd_we_reg    : (cpu_gnt && cpu_we);
    assign mem_addr  = dbg_issue ? cmd_addr_reg  : cpu_addr;
    assign mem_wdata = dbg_issue ? cmd_wdata_reg : cpu_wdata;

    assign dbg_busy   = (state_reg != D_IDLE);
    assign dbg_done   = done_reg;
    assign dbg_drop   = drop_reg;
    assign dbg_rdata  = dbg_rdata_reg;
    assign cpu_rvalid = rvalid_reg;
    assign cpu_rdata  = mem_rdata;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            D_IDLE:   if (dbg_req) state_next = D_PEND;
            D_PEND:   if (dbg_issue) state_next = cmd_we_reg ? D_IDLE : D_RDWAIT;
            D_RDWAIT: state_next = D_IDLE;
            default:  state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_reg     <= D_IDLE;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= 32'd0;
            cmd_wdata_reg <= 32'd0;
            done_reg      <= 1'b0;
            drop_reg      <= 1'b0;
            rvalid_reg    <= 1'b0;
            dbg_rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == D_IDLE && dbg_req) begin
                cmd_we_reg    <= dbg_we;
                cmd_addr_reg  <= dbg_addr;
                cmd_wdata_reg <= dbg_wdata;
            end
            // Writes complete the cycle after issue; reads one cycle later, after capture.
            done_reg   <= (dbg_issue && cmd_we_reg) || (state_reg == D_RDWAIT);
            drop_reg   <= dbg_req && (state_reg != D_IDLE);
            rvalid_reg <= cpu_gnt && !cpu_we;
            if (state_reg == D_RDWAIT)
                dbg_rdata_reg <= mem_rdata;
        end
    end

endmodule
